// File: rtl/regfile_arb_pkg.sv
// Shared defaults, write payload type and round-robin pointer helper for the
// register-file write arbiter.
package regfile_arb_pkg;

  localparam int unsigned DEF_NUM_REQ   = 6;
  localparam int unsigned DEF_NUM_PORTS = 4;
  localparam int unsigned DEF_ADDR_W    = 7;
  localparam int unsigned DEF_DATA_W    = 64;
  localparam int unsigned DEF_MASK_W    = DEF_DATA_W / 8;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] address;
    logic [DEF_DATA_W-1:0] value;
    logic [DEF_MASK_W-1:0] byteMask;
  } write_req_t;

  // Next scan start: one past the last granted requester, else unchanged.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned last,
                                          input logic any_grant, input int unsigned num_req);
    return any_grant ? (last + 1) % num_req : ptr;
  endfunction

endpackage

// File: rtl/regfile_write_arb_alloc.sv
// Combinational round-robin scan: grants up to NUM_PORTS requesters starting at
// rr_ptr, never two grants to the same address, ports filled in scan order.
module regfile_write_arb_alloc
  import regfile_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         enable,
  input  logic [IDX_W-1:0]             rr_ptr,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_address,
  output logic [NUM_REQ-1:0]           req_ready_c,
  output logic [NUM_PORTS*IDX_W-1:0]   port_idx_c,
  output logic [NUM_PORTS-1:0]         port_valid_c,
  output logic [IDX_W-1:0]             last_idx_c,
  output logic                         any_grant_c,
  output logic                         conflict_c
);

  logic [ADDR_W-1:0] addr [NUM_REQ];
  logic [ADDR_W-1:0] granted_addr [NUM_PORTS];
  logic [IDX_W-1:0]  idx;
  logic              clash;
  int unsigned       cnt;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr[i] = req_address[i*ADDR_W +: ADDR_W];
  end

  always_comb begin
    req_ready_c  = '0;
    port_idx_c   = '0;
    port_valid_c = '0;
    last_idx_c   = '0;
    any_grant_c  = 1'b0;
    conflict_c   = 1'b0;
    idx          = '0;
    clash        = 1'b0;
    cnt          = 0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) granted_addr[p] = '0;
    if (enable) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx   = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
        clash = 1'b0;
        for (int unsigned p = 0; p < NUM_PORTS; p++)
          if (port_valid_c[p] && granted_addr[p] == addr[idx]) clash = 1'b1;
        if (req_valid[idx]) begin
          if (clash) begin
            conflict_c = 1'b1;
          end else if (cnt < NUM_PORTS) begin
            // Next free port is the one whose index equals the grant count.
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
              if (p == cnt) begin
                port_valid_c[p]                = 1'b1;
                port_idx_c[p*IDX_W +: IDX_W]   = idx;
                granted_addr[p]                = addr[idx];
              end
            end
            req_ready_c[idx] = 1'b1;
            last_idx_c       = idx;
            any_grant_c      = 1'b1;
            cnt              = cnt + 1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing register-file write ports among requesters; wr_* are
// registered one cycle after the handshake. Define REGFILE_WRITE_ARB_STATS_EN for stall counters.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  localparam int unsigned MASK_W   = DATA_W / 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_address,
  input  logic [NUM_REQ*DATA_W-1:0]     req_value,
  input  logic [NUM_REQ*MASK_W-1:0]     req_byteMask,
  output logic [NUM_PORTS-1:0]          wr_write,
  output logic [NUM_PORTS*ADDR_W-1:0]   wr_address,
  output logic [NUM_PORTS*DATA_W-1:0]   wr_value,
  output logic [NUM_PORTS*MASK_W-1:0]   wr_byteMask
`ifdef REGFILE_WRITE_ARB_STATS_EN
  ,
  output logic [31:0]                   stat_stall_cycles,
  output logic [31:0]                   stat_conflict_cycles
`endif
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8");
  end

  logic [IDX_W-1:0]           rr_ptr;
  logic [NUM_PORTS*IDX_W-1:0] port_idx_c;
  logic [NUM_PORTS-1:0]       port_valid_c;
  logic [IDX_W-1:0]           last_idx_c;
  logic                       any_grant_c;
  logic                       conflict_c;

  logic [ADDR_W-1:0] req_addr_a [NUM_REQ];
  logic [DATA_W-1:0] req_val_a  [NUM_REQ];
  logic [MASK_W-1:0] req_mask_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_addr_a[i] = req_address[i*ADDR_W +: ADDR_W];
    assign req_val_a[i]  = req_value[i*DATA_W +: DATA_W];
    assign req_mask_a[i] = req_byteMask[i*MASK_W +: MASK_W];
  end

  // Reset holds the scan disabled so no grant is offered while reset is low.
  regfile_write_arb_alloc #(
    .NUM_REQ   (NUM_REQ),
    .NUM_PORTS (NUM_PORTS),
    .ADDR_W    (ADDR_W)
  ) u_alloc (
    .enable       (reset),
    .rr_ptr       (rr_ptr),
    .req_valid    (req_valid),
    .req_address  (req_address),
    .req_ready_c  (req_ready),
    .port_idx_c   (port_idx_c),
    .port_valid_c (port_valid_c),
    .last_idx_c   (last_idx_c),
    .any_grant_c  (any_grant_c),
    .conflict_c   (conflict_c)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr      <= '0;
      wr_write    <= '0;
      wr_address  <= '0;
      wr_value    <= '0;
      wr_byteMask <= '0;
    end else begin
      rr_ptr   <= IDX_W'(rr_next(32'(rr_ptr), 32'(last_idx_c), any_grant_c, NUM_REQ));
      wr_write <= port_valid_c;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (port_valid_c[p]) begin
          wr_address[p*ADDR_W +: ADDR_W]  <= req_addr_a[port_idx_c[p*IDX_W +: IDX_W]];
          wr_value[p*DATA_W +: DATA_W]    <= req_val_a[port_idx_c[p*IDX_W +: IDX_W]];
          wr_byteMask[p*MASK_W +: MASK_W] <= req_mask_a[port_idx_c[p*IDX_W +: IDX_W]];
        end else begin
          wr_address[p*ADDR_W +: ADDR_W]  <= '0;
          wr_value[p*DATA_W +: DATA_W]    <= '0;
          wr_byteMask[p*MASK_W +: MASK_W] <= '0;
        end
      end
    end
  end

`ifdef REGFILE_WRITE_ARB_STATS_EN
  logic stall_c;
  assign stall_c = |(req_valid & ~req_ready);

  // Saturating stall / conflict cycle counters.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_stall_cycles    <= '0;
      stat_conflict_cycles <= '0;
    end else begin
      if (stall_c && stat_stall_cycles != 32'hFFFF_FFFF)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (conflict_c && stat_conflict_cycles != 32'hFFFF_FFFF)
        stat_conflict_cycles <= stat_conflict_cycles + 32'd1;
    end
  end
`else
  logic unused_stats_c;
  assign unused_stats_c = conflict_c;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected port writes are queued when a
// cycle is driven and compared one clock later.
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  localparam int NR = 6;
  localparam int NP = 4;
  localparam int AW = 7;
  localparam int DW = 64;
  localparam int MW = 8;

  typedef struct packed {
    logic [NP-1:0]    wr;
    logic [NP*AW-1:0] a;
    logic [NP*DW-1:0] v;
    logic [NP*MW-1:0] m;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*AW-1:0] req_address = '0;
  logic [NR*DW-1:0] req_value = '0;
  logic [NR*MW-1:0] req_byteMask = '0;
  logic [NP-1:0]    wr_write;
  logic [NP*AW-1:0] wr_address;
  logic [NP*DW-1:0] wr_value;
  logic [NP*MW-1:0] wr_byteMask;
`ifdef REGFILE_WRITE_ARB_STATS_EN
  logic [31:0] stat_stall_cycles;
  logic [31:0] stat_conflict_cycles;
`endif

  regfile_write_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_address  (req_address),
    .req_value    (req_value),
    .req_byteMask (req_byteMask),
    .wr_write     (wr_write),
    .wr_address   (wr_address),
    .wr_value     (wr_value),
    .wr_byteMask  (wr_byteMask)
`ifdef REGFILE_WRITE_ARB_STATS_EN
    ,
    .stat_stall_cycles    (stat_stall_cycles),
    .stat_conflict_cycles (stat_conflict_cycles)
`endif
  );

  always #5 clock = ~clock;

  write_req_t    reqs [NR];
  logic [NR-1:0] valid_m = '0;
  logic [2:0]    ptr_m = '0;
  exp_t          sb_q [$];
  int            checks = 0;
  int            failures = 0;
  int            addr_seq = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference allocation from the bench's view of pointer, valids and fields.
  task automatic model(output logic [NR-1:0] rdy, output exp_t e, output logic [2:0] nptr);
    int  cnt;
    int  i;
    bit  blk;
    rdy  = '0;
    e    = '0;
    nptr = ptr_m;
    cnt  = 0;
    if (!reset) begin
      nptr = '0;
      return;
    end
    for (int k = 0; k < NR; k++) begin
      i = (int'(ptr_m) + k) % NR;
      if (!valid_m[i]) continue;
      blk = 1'b0;
      for (int p = 0; p < cnt; p++)
        if (e.a[p*AW +: AW] == reqs[i].address) blk = 1'b1;
      if (blk || cnt >= NP) continue;
      rdy[i]             = 1'b1;
      e.wr[cnt]          = 1'b1;
      e.a[cnt*AW +: AW]  = reqs[i].address;
      e.v[cnt*DW +: DW]  = reqs[i].value;
      e.m[cnt*MW +: MW]  = reqs[i].byteMask;
      cnt++;
      nptr = 3'((i + 1) % NR);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_address[i*AW +: AW]  = reqs[i].address;
      req_value[i*DW +: DW]    = reqs[i].value;
      req_byteMask[i*MW +: MW] = reqs[i].byteMask;
    end
    req_valid = valid_m;
  endtask

  // One clock: drive, check ready, queue expected writes, then check the registered ports.
  task automatic cycle(output logic [NR-1:0] rdy, output logic [NR-1:0] obs);
    exp_t       e;
    exp_t       got_exp;
    logic [2:0] np;
    @(negedge clock);
    drive();
    #1;
    model(rdy, e, np);
    obs = req_ready;
    check("req_ready", req_ready, rdy);
    sb_q.push_back(e);
    @(posedge clock);
    ptr_m = np;
    #1;
    got_exp = sb_q.pop_front();
    check("wr_write", wr_write, got_exp.wr);
    check("wr_address", wr_address, got_exp.a);
    check("wr_value", wr_value, got_exp.v);
    check("wr_byteMask", wr_byteMask, got_exp.m);
  endtask

  task automatic new_req(input int i, input logic [AW-1:0] a);
    reqs[i].address  = a;
    reqs[i].value    = {$urandom, $urandom};
    reqs[i].byteMask = 8'($urandom);
    valid_m[i]       = 1'b1;
  endtask

  task automatic new_seq(input int i);
    addr_seq = (addr_seq + 1) % 128;
    new_req(i, 7'(addr_seq));
  endtask

  task automatic do_reset();
    logic [NR-1:0] r, o;
    reset   = 1'b0;
    valid_m = '0;
    cycle(r, o);
    reset = 1'b1;
  endtask

  task automatic drain();
    logic [NR-1:0] r, o;
    for (int n = 0; n < 12 && valid_m != '0; n++) begin
      cycle(r, o);
      valid_m &= ~r;
    end
    if (valid_m != '0) check("drain_timeout", valid_m, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] r, o;
    for (int i = 0; i < NR; i++) reqs[i] = '0;

    // Held in reset with everything valid: nothing granted, nothing written.
    reset = 1'b0;
    for (int i = 0; i < NR; i++) new_req(i, 7'(8'h20 + i));
    repeat (3) begin
      cycle(r, o);
      check("rst_ready", o, '0);
      check("rst_wr_write", wr_write, '0);
    end
    reset = 1'b1;
    cycle(r, o);
    check("s1_first_grant", o, 6'b001111);
    valid_m &= ~r;
    drain();

    // Four single-cycle requests fill all ports, then pointer sits at 4.
    do_reset();
    for (int i = 0; i < 4; i++) new_req(i, 7'(i + 1));
    cycle(r, o);
    check("s2_ready", o, 6'b001111);
    check("s2_wr_write", wr_write, 4'b1111);
    check("s2_port2_addr", wr_address[2*AW +: AW], 7'h03);
    valid_m = '0;
    for (int i = 0; i < NR; i++) new_seq(i);
    cycle(r, o);
    check("s2_ptr4_grant", o, 6'b110011);
    valid_m &= ~r;
    drain();

    // Six held requests: 0-3 then 4,5 on ports 0,1.
    do_reset();
    for (int i = 0; i < NR; i++) new_seq(i);
    cycle(r, o);
    check("s3_c1", o, 6'b001111);
    valid_m &= ~r;
    cycle(r, o);
    check("s3_c2", o, 6'b110000);
    check("s3_wr_write", wr_write, 4'b0011);
    check("s3_port0_addr", wr_address[0 +: AW], reqs[4].address);
    check("s3_port1_addr", wr_address[AW +: AW], reqs[5].address);
    valid_m &= ~r;

    // Same-address conflict between requesters 1 and 3.
    do_reset();
    new_req(1, 7'h12);
    new_req(3, 7'h12);
    cycle(r, o);
    check("s4_c1", o, 6'b000010);
    valid_m &= ~r;
    cycle(r, o);
    check("s4_c2", o, 6'b001000);
    check("s4_wr_write", wr_write, 4'b0001);
    check("s4_port0_addr", wr_address[0 +: AW], 7'h12);
    valid_m &= ~r;
`ifdef REGFILE_WRITE_ARB_STATS_EN
    check("s4_stall_cycles", stat_stall_cycles, 32'd1);
    check("s4_conflict_cycles", stat_conflict_cycles, 32'd1);
`endif

    // Continuous full load rotates the grant window.
    do_reset();
    for (int i = 0; i < NR; i++) new_seq(i);
    cycle(r, o);
    check("s5_c1", o, 6'b001111);
    for (int i = 0; i < NR; i++) if (r[i]) new_seq(i);
    cycle(r, o);
    check("s5_c2", o, 6'b110011);
    for (int i = 0; i < NR; i++) if (r[i]) new_seq(i);
    cycle(r, o);
    check("s5_c3", o, 6'b111100);
    valid_m = '0;

    // All-zero byte mask is still a write.
    do_reset();
    new_req(2, 7'h55);
    reqs[2].byteMask = '0;
    cycle(r, o);
    check("zmask_ready", o, 6'b000100);
    check("zmask_wr_write", wr_write, 4'b0001);
    check("zmask_mask", wr_byteMask, '0);
    valid_m = '0;

    // Reset asserted mid-traffic discards that cycle's grants.
    do_reset();
    for (int i = 0; i < NR; i++) new_seq(i);
    cycle(r, o);
    valid_m &= ~r;
    reset = 1'b0;
    cycle(r, o);
    check("midrst_ready", o, '0);
    check("midrst_wr_write", wr_write, '0);
    reset = 1'b1;
    drain();

    // Random traffic over a small address space to provoke conflicts.
    do_reset();
    for (int n = 0; n < 80; n++) begin
      for (int i = 0; i < NR; i++)
        if (!valid_m[i] && $urandom_range(0, 1) == 1) new_req(i, 7'($urandom_range(0, 5)));
      cycle(r, o);
      valid_m &= ~r;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
